// File: rtl/core_tcm_arb_pkg.sv
// Shared constants and helpers for the TCM arbiter slice.
package core_tcm_arb_pkg;

    localparam int ARB_MODE_RR  = 0;
    localparam int ARB_MODE_FIX = 1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

    // Index/pointer width that stays at least one bit for single-entry cases.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_tcm_arb_fifo.sv
// Small synchronous FIFO holding the issuing-master ID of each outstanding command.
module core_tcm_arb_fifo
    import core_tcm_arb_pkg::*;
#(
    parameter int DW    = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = id_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/core_tcm_arb.sv
// N-master to one-slave TCM arbiter: comb grant/mux on the command side,
// outstanding-ID FIFO steering in-order responses back to the issuer.
module core_tcm_arb
    import core_tcm_arb_pkg::*;
#(
    parameter int N_MST      = 2,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int OUTS_DEPTH = 2,
    parameter int ARB_MODE   = ARB_MODE_RR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_MST-1:0]      m_cmd_valid,
    output logic [N_MST-1:0]      m_cmd_ready,
    input  logic [N_MST-1:0]      m_cmd_read,
    input  logic [N_MST*AW-1:0]   m_cmd_addr,
    input  logic [N_MST*DW-1:0]   m_cmd_wdata,
    input  logic [N_MST*DW/8-1:0] m_cmd_wmask,
    output logic [N_MST-1:0]      m_rsp_valid,
    input  logic [N_MST-1:0]      m_rsp_ready,
    output logic [N_MST*DW-1:0]   m_rsp_rdata,
    output logic                  s_cmd_valid,
    input  logic                  s_cmd_ready,
    output logic                  s_cmd_read,
    output logic [AW-1:0]         s_cmd_addr,
    output logic [DW-1:0]         s_cmd_wdata,
    output logic [DW/8-1:0]       s_cmd_wmask,
    input  logic                  s_rsp_valid,
    output logic                  s_rsp_ready,
    input  logic [DW-1:0]         s_rsp_rdata,
    output logic                  arb_err
);
    localparam int IW = id_width(N_MST);
    localparam int MW = DW / 8;

    logic [IW-1:0] grant, head;
    logic [IW-1:0] lock_id_q, lock_id_d, rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d, arb_err_q, arb_err_d;
    logic          any_req, fifo_full, fifo_empty, cmd_hs, rsp_hs;

    assign any_req = |m_cmd_valid;

    // Descending scan so the nearest candidate is the last (winning) assignment.
    always_comb begin
        grant = '0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (ARB_MODE == ARB_MODE_FIX) begin
            for (int i = N_MST - 1; i >= 0; i--)
                if (m_cmd_valid[i]) grant = IW'(i);
        end else begin
            for (int k = N_MST; k >= 1; k--)
                if (m_cmd_valid[(int'(rr_ptr_q) + k) % N_MST])
                    grant = IW'((int'(rr_ptr_q) + k) % N_MST);
        end
    end

    always_comb begin
        s_cmd_valid = any_req & ~fifo_full;
        s_cmd_read  = 1'b0;
        s_cmd_addr  = '0;
        s_cmd_wdata = '0;
        s_cmd_wmask = '0;
        m_cmd_ready = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (IW'(i) == grant) begin
                s_cmd_read     = m_cmd_read[i];
                s_cmd_addr     = m_cmd_addr[i*AW +: AW];
                s_cmd_wdata    = m_cmd_wdata[i*DW +: DW];
                s_cmd_wmask    = m_cmd_wmask[i*MW +: MW];
                m_cmd_ready[i] = any_req & s_cmd_ready & ~fifo_full;
            end
        end
    end

    always_comb begin
        m_rsp_valid = '0;
        s_rsp_ready = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (IW'(i) == head) begin
                m_rsp_valid[i] = s_rsp_valid & ~fifo_empty;
                s_rsp_ready    = m_rsp_ready[i] & ~fifo_empty;
            end
        end
    end

    assign m_rsp_rdata = {N_MST{s_rsp_rdata}};
    assign cmd_hs      = s_cmd_valid & s_cmd_ready;
    assign rsp_hs      = s_rsp_valid & s_rsp_ready;
    assign arb_err     = arb_err_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        arb_err_d = arb_err_q | (s_rsp_valid & fifo_empty);
        if (cmd_hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = grant;
        end else if (s_cmd_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= IW'(N_MST - 1);
            arb_err_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            arb_err_q <= arb_err_d;
        end
    end

    core_tcm_arb_fifo #(
        .DW    (IW),
        .DEPTH (OUTS_DEPTH)
    ) u_outs_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_hs),
        .wdata_i (grant),
        .pop_i   (rsp_hs),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_core_tcm_arb.sv
// Directed bench: a round-robin and a fixed-priority instance on shared stimulus.
module tb_core_tcm_arb;
    import core_tcm_arb_pkg::*;

    localparam logic [15:0] A0  = 16'h1000, A1 = 16'h2000;
    localparam logic [31:0] WD0 = 32'h1111_0000, WD1 = 32'h2222_0001;
    localparam logic [3:0]  WM0 = 4'hF, WM1 = 4'h3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  m_cmd_valid = '0, m_rsp_ready = '0, m_cmd_read;
    logic [31:0] m_cmd_addr;
    logic [63:0] m_cmd_wdata;
    logic [7:0]  m_cmd_wmask;
    logic        s_cmd_ready = 1'b0, s_rsp_valid = 1'b0;
    logic [31:0] s_rsp_rdata = '0;

    logic [1:0]  m_cmd_ready, m_rsp_valid;
    logic [63:0] m_rsp_rdata;
    logic        s_cmd_valid, s_cmd_read, s_rsp_ready, arb_err;
    logic [15:0] s_cmd_addr;
    logic [31:0] s_cmd_wdata;
    logic [3:0]  s_cmd_wmask;

    logic [1:0]  f_cmd_ready, f_rsp_valid;
    logic [63:0] f_rsp_rdata;
    logic        f_cmd_valid, f_cmd_read, f_rsp_ready, f_err;
    logic [15:0] f_cmd_addr;
    logic [31:0] f_cmd_wdata;
    logic [3:0]  f_cmd_wmask;

    int n_vec = 0, n_err = 0;

    assign m_cmd_read  = 2'b01;
    assign m_cmd_addr  = {A1, A0};
    assign m_cmd_wdata = {WD1, WD0};
    assign m_cmd_wmask = {WM1, WM0};

    always #5 clk = ~clk;

    core_tcm_arb #(.N_MST(2), .AW(16), .DW(32), .OUTS_DEPTH(2), .ARB_MODE(ARB_MODE_RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_read(m_cmd_read),
        .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .arb_err(arb_err)
    );

    core_tcm_arb #(.N_MST(2), .AW(16), .DW(32), .OUTS_DEPTH(2), .ARB_MODE(ARB_MODE_FIX)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(f_cmd_ready), .m_cmd_read(m_cmd_read),
        .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(f_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(f_rsp_rdata),
        .s_cmd_valid(f_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(f_cmd_read),
        .s_cmd_addr(f_cmd_addr), .s_cmd_wdata(f_cmd_wdata), .s_cmd_wmask(f_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(f_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .arb_err(f_err)
    );

    typedef struct {
        logic [1:0] vld;
        logic       crdy;
        logic       rv;
        logic [1:0] rrdy;
        logic [1:0] e_crdy;
        logic       e_scv;
        logic       chk_m;
        logic       e_m;
        logic [1:0] e_rv;
        logic       e_srr;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_mst(input string nm, input logic m);
        chk({nm, "_addr"},  64'(s_cmd_addr),  m ? 64'(A1)  : 64'(A0));
        chk({nm, "_wdata"}, 64'(s_cmd_wdata), m ? 64'(WD1) : 64'(WD0));
        chk({nm, "_wmask"}, 64'(s_cmd_wmask), m ? 64'(WM1) : 64'(WM0));
        chk({nm, "_read"},  64'(s_cmd_read),  m ? 64'd0    : 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] vld, input logic crdy, input logic rv, input logic [1:0] rrdy);
        m_cmd_valid = vld;
        s_cmd_ready = crdy;
        s_rsp_valid = rv;
        m_rsp_ready = rrdy;
        #2;
    endtask

    initial begin
        // Round-robin from reset (rr_ptr=1 -> m0 first), slave answers one cycle after each command.
        tbl[0] = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1};
        tbl[2] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1};
        tbl[4] = '{2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[5] = '{2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

        #2;
        chk("rst_scv",    64'(s_cmd_valid), 64'd0);
        chk("rst_crdy",   64'(m_cmd_ready), 64'd0);
        chk("rst_rv",     64'(m_rsp_valid), 64'd0);
        chk("rst_srr",    64'(s_rsp_ready), 64'd0);
        chk("rst_err",    64'(arb_err),     64'd0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            s_rsp_rdata = 32'hA500_0000 | 32'(i);
            drive(tbl[i].vld, tbl[i].crdy, tbl[i].rv, tbl[i].rrdy);
            chk($sformatf("tbl%0d_crdy", i), 64'(m_cmd_ready), 64'(tbl[i].e_crdy));
            chk($sformatf("tbl%0d_scv", i),  64'(s_cmd_valid), 64'(tbl[i].e_scv));
            chk($sformatf("tbl%0d_rv", i),   64'(m_rsp_valid), 64'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_srr", i),  64'(s_rsp_ready), 64'(tbl[i].e_srr));
            if (tbl[i].chk_m) chk_mst($sformatf("tbl%0d", i), tbl[i].e_m);
            if (tbl[i].rv)
                chk($sformatf("tbl%0d_rdata", i), m_rsp_rdata, {2{s_rsp_rdata}});
            tick();
        end
        chk("rr_err_clear", 64'(arb_err), 64'd0);

        // Lock: m1 stalls, m0 joins, grant stays with m1 until accepted.
        drive(2'b10, 1'b0, 1'b0, 2'b00);
        chk("lock_scv", 64'(s_cmd_valid), 64'd1);
        chk("lock_crdy", 64'(m_cmd_ready), 64'd0);
        chk("lock_addr0", 64'(s_cmd_addr), 64'(A1));
        tick();
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        chk("lock_addr1", 64'(s_cmd_addr), 64'(A1));
        tick();
        drive(2'b11, 1'b0, 1'b0, 2'b00);
        chk("lock_addr2", 64'(s_cmd_addr), 64'(A1));
        tick();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("lock_accept", 64'(m_cmd_ready), 64'b10);
        chk("lock_addr3", 64'(s_cmd_addr), 64'(A1));
        tick();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        chk("after_lock_crdy", 64'(m_cmd_ready), 64'b01);
        chk_mst("after_lock", 1'b0);
        tick();

        // FIFO full (head = m1); response held back by master, then no pop-to-push bypass.
        drive(2'b11, 1'b1, 1'b1, 2'b00);
        chk("full_scv", 64'(s_cmd_valid), 64'd0);
        chk("full_crdy", 64'(m_cmd_ready), 64'd0);
        chk("hold_rv0", 64'(m_rsp_valid), 64'b10);
        chk("hold_srr0", 64'(s_rsp_ready), 64'd0);
        tick();
        drive(2'b11, 1'b1, 1'b1, 2'b00);
        chk("hold_rv1", 64'(m_rsp_valid), 64'b10);
        chk("hold_srr1", 64'(s_rsp_ready), 64'd0);
        tick();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        chk("pop_srr", 64'(s_rsp_ready), 64'd1);
        chk("no_bypass_scv", 64'(s_cmd_valid), 64'd0);
        tick();
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        chk("refill_scv", 64'(s_cmd_valid), 64'd1);
        chk("refill_crdy", 64'(m_cmd_ready), 64'b10);
        chk("refill_addr", 64'(s_cmd_addr), 64'(A1));
        tick();
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        chk("drain_rv0", 64'(m_rsp_valid), 64'b01);
        tick();
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        chk("drain_rv1", 64'(m_rsp_valid), 64'b10);
        chk("drain_err", 64'(arb_err), 64'd0);
        tick();

        // Stray response while empty.
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        chk("stray_rv", 64'(m_rsp_valid), 64'd0);
        chk("stray_srr", 64'(s_rsp_ready), 64'd0);
        tick();
        drive(2'b00, 1'b1, 1'b0, 2'b11);
        chk("stray_err", 64'(arb_err), 64'd1);
        tick();
        chk("stray_err_sticky", 64'(arb_err), 64'd1);

        // Mid-burst async reset with one outstanding command and m1 locked.
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        chk("pre_rst_crdy", 64'(m_cmd_ready), 64'b01);
        tick();
        drive(2'b10, 1'b0, 1'b0, 2'b11);
        chk("pre_rst_addr", 64'(s_cmd_addr), 64'(A1));
        tick();
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b11);
        chk("mid_rst_srr", 64'(s_rsp_ready), 64'd0);
        chk("mid_rst_err", 64'(arb_err), 64'd0);
        chk("mid_rst_scv", 64'(s_cmd_valid), 64'd0);
        chk("mid_rst_crdy", 64'(m_cmd_ready), 64'd0);
        chk("mid_rst_rv", 64'(m_rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        chk("post_rst_crdy", 64'(m_cmd_ready), 64'b01);
        chk("post_rst_addr", 64'(s_cmd_addr), 64'(A0));
        tick();

        // Fixed priority on the second instance.
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        tick();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("fix_crdy0", 64'(f_cmd_ready), 64'b01);
        chk("fix_addr0", 64'(f_cmd_addr), 64'(A0));
        tick();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        chk("fix_crdy1", 64'(f_cmd_ready), 64'b01);
        tick();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        chk("fix_full_scv", 64'(f_cmd_valid), 64'd0);
        chk("fix_rv", 64'(f_rsp_valid), 64'b01);
        chk("fix_srr", 64'(f_rsp_ready), 64'd1);
        tick();
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        chk("fix_crdy2", 64'(f_cmd_ready), 64'b01);
        tick();
        drive(2'b10, 1'b1, 1'b1, 2'b11);
        chk("fix_full_scv2", 64'(f_cmd_valid), 64'd0);
        tick();
        drive(2'b10, 1'b1, 1'b0, 2'b11);
        chk("fix_m1_crdy", 64'(f_cmd_ready), 64'b10);
        chk("fix_m1_addr", 64'(f_cmd_addr), 64'(A1));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
